piso_shift_tx: RTL
==================

PISO_SHIFT_TX -- requirements
Module: piso_shift_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits per parallel word, legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.
REQ-003 SHALL have port: clk  input  1  single clock, all state updates on the rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port: load_valid  input  1  parallel word offered.
REQ-006 SHALL have port: load_ready  output  1  block can accept a word this cycle.
REQ-007 SHALL have port: load_data  input  WIDTH  parallel word.
REQ-008 SHALL have port: ser_ready  input  1  downstream receiver consumes the current bit.
REQ-009 SHALL have port: ser_valid  output  1  ser_out holds a valid bit.
REQ-010 SHALL have port: ser_out  output  1  current serial bit.
REQ-011 SHALL have port: ser_last  output  1  current bit is the final bit of the word.
REQ-012 SHALL have port: busy  output  1  a word is in progress (state SHIFT).

Function
REQ-013 SHALL implement two states: IDLE and SHIFT.
REQ-014 SHALL define a load handshake as load_valid && load_ready at a rising edge.
REQ-015 SHALL define a bit transfer as ser_valid && ser_ready at a rising edge.
REQ-016 IDLE: SHALL drive load_ready=1, ser_valid=0, ser_last=0 and busy=0; on a load handshake it SHALL capture load_data into the shift register, clear the bit counter and go to SHIFT.
REQ-017 SHIFT: SHALL drive ser_valid=1 and busy=1; ser_out SHALL be the shift-register bit selected by MSB_FIRST, driven from the register (no combinational path from load_data).
REQ-018 SHALL show the first bit of an accepted word in the cycle immediately after the load handshake edge (latency 1).
REQ-019 On each bit transfer the shift register SHALL shift by one toward the output end and the counter SHALL increment.
REQ-020 When ser_ready=0, SHALL hold ser_out, ser_last, the counter and the shift register unchanged (stall of any length).
REQ-021 SHALL assert ser_last exactly when the counter equals WIDTH-1 in SHIFT.
REQ-022 In SHIFT, load_ready SHALL equal ser_last && ser_ready; otherwise load_ready SHALL be 0.
REQ-023 Last-bit transfer with no load handshake at the same edge: SHALL go to IDLE.
REQ-024 Last-bit transfer with a load handshake at the same edge: SHALL stay in SHIFT, reload with the new word and clear the counter (back-to-back, no idle bubble).
REQ-025 load_valid SHALL be ignored whenever load_ready=0; no word is dropped or corrupted.
REQ-026 Counter width SHALL be clog2(WIDTH); the counter SHALL never exceed WIDTH-1 and SHALL NOT wrap within a word.

Reset
REQ-027 When rst_n=0 at a rising edge, SHALL go to IDLE, clear the shift register and clear the counter.
REQ-028 Outputs after reset SHALL be: load_ready=1, ser_valid=0, ser_out=0, ser_last=0, busy=0.
REQ-029 Reset mid-word SHALL abandon the word, with no further bits emitted.
REQ-030 A load handshake coincident with reset SHALL be discarded.

Structure
REQ-031 SHALL place the state encodings (IDLE=1'b0, SHIFT=1'b1) in a shared package piso_pkg, together with a constant PISO_MAX_WIDTH=32.
REQ-032 SHALL use one sub-module, bit_counter (parameterised width, synchronous clear, enable, terminal-count flag), for the counter; all other logic is inline.

Verification
REQ-033 SHALL verify: WIDTH=8, MSB_FIRST=1, load 8'hA5, ser_ready=1 -> ser_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles; ser_last on the 8th only; then IDLE.
REQ-034 SHALL verify: MSB_FIRST=0, load 8'hA5 -> ser_out 1,0,1,0,0,1,0,1 (LSB first); busy high for exactly 8 cycles.
REQ-035 SHALL verify: load 8'hA5, then 8'h3C presented during the last-bit cycle -> 16 contiguous valid bits (A5 then 0,0,1,1,1,1,0,0); ser_valid never drops.
REQ-036 SHALL verify: load 8'hF0, ser_ready=0 for 5 cycles after bit 2 -> ser_out held at 1, counter frozen; stream resumes with the remaining bits intact.
REQ-037 SHALL verify: load_valid with 8'h55 while bit 3 of 8'hA5 is shifting -> load_ready=0, 8'h55 not captured; A5 completes unaltered.
REQ-038 SHALL verify: rst_n=0 for one cycle after bit 4 -> next cycle ser_valid=0, load_ready=1, busy=0; a fresh load of 8'h81 serialises correctly.

Source files
------------

// File: rtl/piso_pkg.sv
// -----------------------------------------------------------------------------
// piso_pkg
// Shared definitions for the parallel-in / serial-out transmitter.
//   piso_state_e   : two-state controller encoding (IDLE=0, SHIFT=1)
//   PISO_MAX_WIDTH : largest supported parallel word width
// -----------------------------------------------------------------------------
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

  localparam int PISO_MAX_WIDTH = 32;

endpackage : piso_pkg

// File: rtl/bit_counter.sv
// -----------------------------------------------------------------------------
// bit_counter
// Up-counter with synchronous clear, count enable and a terminal-count flag.
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   synchronous active-low reset (clears the count)
//   clr     in   synchronous clear, has priority over en
//   en      in   increment by one
//   tc      out  count currently equals TC_VAL
// The owner is responsible for never enabling past TC_VAL; the counter does
// not saturate on its own.
// -----------------------------------------------------------------------------
module bit_counter #(
  parameter int CNT_W  = 3,
  parameter int TC_VAL = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_CNT = CNT_W'(TC_VAL);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == TC_CNT);

endmodule : bit_counter

// File: rtl/piso_shift_tx.sv
// -----------------------------------------------------------------------------
// piso_shift_tx
// Parallel-in, serial-out transmitter. Accepts a WIDTH-bit word and emits it
// one bit per transfer, MSB or LSB first.
// Parameters:
//   WIDTH      bits per word (2..32)
//   MSB_FIRST  1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   synchronous active-low reset
//   load_valid  in   parallel word offered
//   load_ready  out  word can be accepted this cycle
//   load_data   in   parallel word
//   ser_ready   in   receiver consumes the current bit
//   ser_valid   out  ser_out holds a valid bit
//   ser_out     out  current serial bit (always from the shift register)
//   ser_last    out  current bit is the final bit of the word
//   busy        out  a word is in progress; this is the controller state
//                    (0=IDLE, 1=SHIFT) brought out for observation
//
// Handshake semantics (both sides): a transfer happens at a rising edge where
// valid && ready are both 1. valid never depends on ready; load_ready does
// depend on ser_ready so a new word can be taken on the same edge the last
// bit leaves, giving gap-free back-to-back words.
// -----------------------------------------------------------------------------
module piso_shift_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_ready,
  output logic             ser_valid,
  output logic             ser_out,
  output logic             ser_last,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  piso_state_e      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;

  logic load_hs;
  logic bit_xfer;
  logic cnt_tc;
  logic cnt_clr;
  logic cnt_en;

  // Output decode, all from registered state.
  assign busy       = (state_q == SHIFT);
  assign ser_valid  = busy;
  assign ser_last   = busy && cnt_tc;
  assign load_ready = !busy || (ser_last && ser_ready);
  assign ser_out    = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

  assign load_hs  = load_valid && load_ready;
  assign bit_xfer = ser_valid && ser_ready;

  // A new word restarts the count; the last bit leaving also clears it so the
  // counter never advances past WIDTH-1.
  assign cnt_clr = load_hs || (bit_xfer && cnt_tc);
  assign cnt_en  = bit_xfer && !cnt_tc;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    if (load_hs) begin
      // Covers both a load from IDLE and a reload on the last-bit edge.
      shreg_d = load_data;
      state_d = SHIFT;
    end else if (bit_xfer) begin
      if (MSB_FIRST) begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      end else begin
        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
      end
      if (cnt_tc) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  bit_counter #(
    .CNT_W  (CNT_W),
    .TC_VAL (WIDTH - 1)
  ) u_bit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

endmodule : piso_shift_tx
